// File: rtl/lsu_store_buffer.sv
// ---------------------------------------------------------------------------
// lsu_store_buffer
//
// Load/store unit core placed between the MEM stage and a single-port
// synchronous data RAM. Stores are posted into a DEPTH-entry FIFO (with
// optional write-combining into the newest entry) and written to RAM in
// cycles where the port is otherwise idle. Loads read the RAM with one cycle
// of latency and are patched byte-by-byte with any still-buffered store data.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready ignores valid)
//   i_req_wren            1 = store, 0 = load
//   i_req_addr            byte address (only [ADDR_W-1:0] used)
//   i_req_wdata           right-aligned store data
//   i_req_funct3          RV32 load/store width/sign encoding
//   i_fence               hold off new requests until the buffer is empty
//   o_ld_valid/o_ld_data  load result, one cycle after acceptance
//   o_misaligned          one-cycle pulse after a misaligned/illegal request
//   o_mem_*               RAM word index, write data, byte mask, write strobe
//   i_mem_rdata           RAM read data, one cycle after o_mem_addr
//   o_sb_count/o_sb_empty store-buffer occupancy
// ---------------------------------------------------------------------------
module lsu_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 16,
  parameter int COMBINE_EN = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_wren,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  input  logic [2:0]               i_req_funct3,
  input  logic                     i_fence,
  output logic                     o_ld_valid,
  output logic [31:0]              o_ld_data,
  output logic                     o_misaligned,
  output logic [ADDR_W-3:0]        o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  output logic [3:0]               o_mem_bmask,
  output logic                     o_mem_wren,
  input  logic [31:0]              i_mem_rdata,
  output logic [$clog2(DEPTH):0]   o_sb_count,
  output logic                     o_sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W - 2;

  // Store-buffer storage: word index, lane-aligned data, byte mask
  logic [IDX_W-1:0] sb_idx  [DEPTH];
  logic [31:0]      sb_data [DEPTH];
  logic [3:0]       sb_mask [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] newest;
  logic [PTR_W-1:0] scan_ptr;
  logic [CNT_W-1:0] count;

  // Request decode
  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_size;
  logic             req_illegal;
  logic             req_bad;
  logic [3:0]       st_mask;
  logic [31:0]      st_data;

  // Per-cycle control
  logic accept;
  logic ld_go;
  logic st_go;
  logic drain;
  logic combine;
  logic push;

  // Load pipeline
  logic [31:0] fwd_data_c;
  logic [3:0]  fwd_mask_c;
  logic [31:0] fwd_data_q;
  logic [3:0]  fwd_mask_q;
  logic        ld_pend;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        mis_q;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] ld_result;
  logic [31:0] ld_hold;

  logic unused_addr_bits;

  assign req_off          = i_req_addr[1:0];
  assign req_idx          = i_req_addr[ADDR_W-1:2];
  assign req_size         = i_req_funct3[1:0];
  assign unused_addr_bits = ^i_req_addr[31:ADDR_W];

  // Illegal encodings: stores only have SB/SH/SW; loads have no 011/110/111.
  // Illegal and misaligned requests are accepted but otherwise ignored.
  always_comb begin
    req_illegal = 1'b0;
    if (i_req_wren) begin
      req_illegal = i_req_funct3[2] | (req_size == 2'b11);
    end else begin
      req_illegal = (req_size == 2'b11) | (i_req_funct3 == 3'b110);
    end
    req_bad = req_illegal
            | ((req_size == 2'b01) & req_off[0])
            | ((req_size == 2'b10) & (req_off != 2'b00));
  end

  // Replicate store data into every lane so the mask alone picks the bytes
  always_comb begin
    st_mask = 4'b1111;
    st_data = i_req_wdata;
    case (req_size)
      2'b00: begin
        st_mask = 4'b0001 << req_off;
        st_data = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = req_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_req_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = i_req_wdata;
      end
    endcase
  end

  assign o_sb_empty  = (count == '0);
  assign o_sb_count  = count;
  assign o_req_ready = (count != CNT_W'(DEPTH)) & ~(i_fence & ~o_sb_empty);

  assign accept = i_req_valid & o_req_ready;
  assign ld_go  = accept & ~i_req_wren & ~req_bad;
  assign st_go  = accept &  i_req_wren & ~req_bad;

  // The RAM port drains the head only in cycles no accepted load or store
  // claims it; this lets back-to-back stores accumulate and combine. Reset
  // suppresses the strobe so no buffered store leaks out while clearing.
  assign drain  = ~i_reset & ~o_sb_empty & ~ld_go & ~st_go;

  assign newest = tail - PTR_W'(1);

  // Merging into an entry that is leaving this cycle would lose the bytes
  assign combine = (COMBINE_EN != 0) & st_go & ~o_sb_empty
                 & (sb_idx[newest] == req_idx)
                 & ~(drain & (newest == head));
  assign push    = st_go & ~combine;

  // Forwarding scan from oldest to newest so the youngest byte wins
  always_comb begin
    fwd_data_c = '0;
    fwd_mask_c = '0;
    scan_ptr   = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_ptr = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (sb_idx[scan_ptr] == req_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_mask[scan_ptr][b]) begin
            fwd_mask_c[b]         = 1'b1;
            fwd_data_c[8*b +: 8]  = sb_data[scan_ptr][8*b +: 8];
          end
        end
      end
    end
  end

  assign o_mem_wren  = drain;
  assign o_mem_addr  = ld_go ? req_idx : sb_idx[head];
  assign o_mem_wdata = sb_data[head];
  assign o_mem_bmask = sb_mask[head];

  // Control state, pointers and the load pipeline registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ld_pend    <= 1'b0;
      mis_q      <= 1'b0;
      ld_funct3  <= '0;
      ld_off     <= '0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      ld_hold    <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      count   <= count + CNT_W'(push) - CNT_W'(drain);
      ld_pend <= ld_go;
      mis_q   <= accept & req_bad;
      if (ld_go) begin
        ld_funct3  <= i_req_funct3;
        ld_off     <= req_off;
        fwd_data_q <= fwd_data_c;
        fwd_mask_q <= fwd_mask_c;
      end
      if (ld_pend) begin
        ld_hold <= ld_result;
      end
    end
  end

  // Entry payload needs no reset: count decides which entries are live
  always_ff @(posedge i_clk) begin
    if (push) begin
      sb_idx[tail]  <= req_idx;
      sb_data[tail] <= st_data;
      sb_mask[tail] <= st_mask;
    end else if (combine) begin
      sb_mask[newest] <= sb_mask[newest] | st_mask;
      for (int b = 0; b < 4; b++) begin
        if (st_mask[b]) begin
          sb_data[newest][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  // Second load cycle: patch RAM bytes with forwarded ones, then align/extend
  always_comb begin
    merged = i_mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_mask_q[b]) begin
        merged[8*b +: 8] = fwd_data_q[8*b +: 8];
      end
    end
    shifted = merged >> {ld_off, 3'b000};
    case (ld_funct3)
      3'b000:  ld_result = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_result = {24'b0, shifted[7:0]};
      3'b101:  ld_result = {16'b0, shifted[15:0]};
      default: ld_result = merged;
    endcase
  end

  assign o_ld_valid   = ld_pend;
  assign o_ld_data    = ld_pend ? ld_result : ld_hold;
  assign o_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_lsu_store_buffer
//
// Directed table of per-cycle requests and expected observations for the
// store buffer, plus hand-written fence/reset sequences. A byte-maskable RAM
// with one cycle of read latency sits on the memory port.
// ---------------------------------------------------------------------------
module tb_lsu_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wren;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        fence;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misaligned;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;
  logic [31:0] mem_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_store_buffer #(.DEPTH(4), .ADDR_W(16), .COMBINE_EN(1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_wren   (req_wren),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_funct3 (req_funct3),
    .i_fence      (fence),
    .o_ld_valid   (ld_valid),
    .o_ld_data    (ld_data),
    .o_misaligned (misaligned),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_bmask  (mem_bmask),
    .o_mem_wren   (mem_wren),
    .i_mem_rdata  (mem_rdata),
    .o_sb_count   (sb_count),
    .o_sb_empty   (sb_empty)
  );

  // RAM with byte enables and registered read
  logic [31:0] ram [0:16383];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, new_w, input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= byte_merge(ram[mem_addr], mem_wdata, mem_bmask);
    mem_rdata <= ram[mem_addr];
  end

  // One row = one cycle: request applied, observations before the next edge
  typedef struct {
    logic        v, w, fen;
    logic [31:0] a, d;
    logic [2:0]  f;
    logic        rdy, wr, ldv, mis;
    logic [2:0]  cnt;
    logic        ca, cw, cd;
    logic [13:0] ma;
    logic [3:0]  bm;
    logic [31:0] wd, ld;
  } vec_t;

  vec_t tbl [48];
  int   n_vec = 0;

  task automatic row(input logic v, w, input logic [31:0] a, d, input logic [2:0] f,
                     input logic fen, input logic rdy, wr, input logic [2:0] cnt,
                     input logic ldv, mis);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.f = f; t.fen = fen;
    t.rdy = rdy; t.wr = wr; t.cnt = cnt; t.ldv = ldv; t.mis = mis;
    t.ca = 1'b0; t.cw = 1'b0; t.cd = 1'b0;
    t.ma = '0; t.bm = '0; t.wd = '0; t.ld = '0;
    tbl[n_vec] = t;
    n_vec++;
  endtask

  task automatic exp_mem(input logic [13:0] ma, input logic [3:0] bm, input logic [31:0] wd);
    tbl[n_vec-1].ca = 1'b1; tbl[n_vec-1].ma = ma;
    tbl[n_vec-1].cw = 1'b1; tbl[n_vec-1].bm = bm; tbl[n_vec-1].wd = wd;
  endtask

  task automatic exp_addr(input logic [13:0] ma);
    tbl[n_vec-1].ca = 1'b1; tbl[n_vec-1].ma = ma;
  endtask

  task automatic exp_ld(input logic [31:0] x);
    tbl[n_vec-1].cd = 1'b1; tbl[n_vec-1].ld = x;
  endtask

  task automatic apply_stimulus(input logic v, w, input logic [31:0] a, d,
                                input logic [2:0] f, input logic fen);
    @(negedge clk);
    req_valid = v; req_wren = w; req_addr = a; req_wdata = d;
    req_funct3 = f; fence = fen;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, need 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_row(input int i);
    vec_t t;
    t = tbl[i];
    apply_stimulus(t.v, t.w, t.a, t.d, t.f, t.fen);
    #2;
    check_output($sformatf("row%0d ready", i),    32'(req_ready),  32'(t.rdy));
    check_output($sformatf("row%0d mem_wren", i), 32'(mem_wren),   32'(t.wr));
    check_output($sformatf("row%0d count", i),    32'(sb_count),   32'(t.cnt));
    check_output($sformatf("row%0d empty", i),    32'(sb_empty),   32'(t.cnt == 3'd0));
    check_output($sformatf("row%0d ld_valid", i), 32'(ld_valid),   32'(t.ldv));
    check_output($sformatf("row%0d misalign", i), 32'(misaligned), 32'(t.mis));
    if (t.ca) check_output($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(t.ma));
    if (t.cw) begin
      check_output($sformatf("row%0d bmask", i), 32'(mem_bmask), 32'(t.bm));
      check_output($sformatf("row%0d wdata", i), mem_wdata, t.wd);
    end
    if (t.cd) check_output($sformatf("row%0d ld_data", i), ld_data, t.ld);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; fence = 1'b0;

    //  v  w  addr       wdata         f3  fen  rdy wr cnt ldv mis
    row(1, 1, 32'h100, 32'h11223344, 3'd2, 0,   1, 0, 3'd0, 0, 0);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 1, 3'd1, 0, 0); exp_mem(14'h40, 4'hF, 32'h11223344);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 0, 0);
    row(1, 1, 32'h200, 32'hAABBCCDD, 3'd2, 0,   1, 0, 3'd0, 0, 0);
    row(1, 0, 32'h202, 32'h0,        3'd4, 0,   1, 0, 3'd1, 0, 0); exp_addr(14'h80);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 1, 3'd1, 1, 0); exp_mem(14'h80, 4'hF, 32'hAABBCCDD); exp_ld(32'h000000BB);
    row(1, 1, 32'h301, 32'h80,       3'd0, 0,   1, 0, 3'd0, 0, 0);
    row(1, 1, 32'h303, 32'h7F,       3'd0, 0,   1, 0, 3'd1, 0, 0);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 1, 3'd1, 0, 0); exp_mem(14'hC0, 4'hA, 32'h7F808080);
    row(1, 0, 32'h302, 32'h0,        3'd1, 0,   1, 0, 3'd0, 0, 0); exp_addr(14'hC0);
    row(1, 0, 32'h100, 32'h0,        3'd2, 0,   1, 0, 3'd0, 1, 0); exp_addr(14'h40); exp_ld(32'h00007F00);
    row(1, 0, 32'h301, 32'h0,        3'd0, 0,   1, 0, 3'd0, 1, 0); exp_ld(32'h11223344);
    row(1, 0, 32'h300, 32'h0,        3'd5, 0,   1, 0, 3'd0, 1, 0); exp_ld(32'hFFFFFF80);
    row(1, 0, 32'h300, 32'h0,        3'd1, 0,   1, 0, 3'd0, 1, 0); exp_ld(32'h00008000);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 1, 0); exp_ld(32'hFFFF8000);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 0, 0); exp_ld(32'hFFFF8000);
    row(1, 0, 32'h102, 32'h0,        3'd2, 0,   1, 0, 3'd0, 0, 0);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 0, 1);
    row(1, 1, 32'h101, 32'h1234,     3'd1, 0,   1, 0, 3'd0, 0, 0);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 0, 1);
    row(1, 0, 32'h100, 32'h0,        3'd3, 0,   1, 0, 3'd0, 0, 0);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 0, 1); exp_ld(32'hFFFF8000);
    row(1, 1, 32'h400, 32'hA0000000, 3'd2, 0,   1, 0, 3'd0, 0, 0);
    row(1, 1, 32'h404, 32'hA1111111, 3'd2, 0,   1, 0, 3'd1, 0, 0);
    row(1, 1, 32'h408, 32'hA2222222, 3'd2, 0,   1, 0, 3'd2, 0, 0);
    row(1, 1, 32'h40C, 32'hA3333333, 3'd2, 0,   1, 0, 3'd3, 0, 0);
    row(1, 0, 32'h404, 32'h0,        3'd2, 0,   0, 1, 3'd4, 0, 0); exp_mem(14'h100, 4'hF, 32'hA0000000);
    row(1, 0, 32'h404, 32'h0,        3'd2, 0,   1, 0, 3'd3, 0, 0); exp_addr(14'h101);
    row(1, 0, 32'h40C, 32'h0,        3'd2, 0,   1, 0, 3'd3, 1, 0); exp_addr(14'h103); exp_ld(32'hA1111111);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 1, 3'd3, 1, 0); exp_mem(14'h101, 4'hF, 32'hA1111111); exp_ld(32'hA3333333);
    row(1, 1, 32'h500, 32'h55,       3'd2, 1,   0, 1, 3'd2, 0, 0); exp_mem(14'h102, 4'hF, 32'hA2222222);
    row(1, 1, 32'h500, 32'h55,       3'd2, 1,   0, 1, 3'd1, 0, 0); exp_mem(14'h103, 4'hF, 32'hA3333333);
    row(1, 1, 32'h500, 32'h55,       3'd2, 1,   1, 0, 3'd0, 0, 0);
    row(0, 0, 32'h0,   32'h0,        3'd0, 1,   0, 1, 3'd1, 0, 0); exp_mem(14'h140, 4'hF, 32'h55);
    row(0, 0, 32'h0,   32'h0,        3'd0, 0,   1, 0, 3'd0, 0, 0);

    // Reset state
    @(negedge clk); @(negedge clk); #2;
    check_output("reset count",    32'(sb_count),   32'd0);
    check_output("reset empty",    32'(sb_empty),   32'd1);
    check_output("reset ld_valid", 32'(ld_valid),   32'd0);
    check_output("reset misalign", 32'(misaligned), 32'd0);
    check_output("reset mem_wren", 32'(mem_wren),   32'd0);
    check_output("reset ready",    32'(req_ready),  32'd1);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) run_row(i);

    // Three buffered stores, fence drains one, then reset mid-drain
    apply_stimulus(1, 1, 32'h600, 32'h61, 3'd2, 0);
    apply_stimulus(1, 1, 32'h604, 32'h62, 3'd2, 0);
    apply_stimulus(1, 1, 32'h608, 32'h63, 3'd2, 0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 3'd0, 1); #2;
    check_output("fence count3",   32'(sb_count),  32'd3);
    check_output("fence ready",    32'(req_ready), 32'd0);
    check_output("fence drain",    32'(mem_wren),  32'd1);
    check_output("fence drain addr", 32'(mem_addr), 32'h180);
    apply_stimulus(0, 0, 32'h0, 32'h0, 3'd0, 1); reset = 1'b1; #2;
    check_output("rst cycle count", 32'(sb_count), 32'd2);
    check_output("rst cycle wren",  32'(mem_wren), 32'd0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 3'd0, 0); reset = 1'b0; #2;
    check_output("post rst count", 32'(sb_count),  32'd0);
    check_output("post rst empty", 32'(sb_empty),  32'd1);
    check_output("post rst wren",  32'(mem_wren),  32'd0);
    check_output("post rst ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 0, 32'h0, 32'h0, 3'd0, 0); #2;
      check_output($sformatf("post rst idle%0d wren", i), 32'(mem_wren), 32'd0);
      check_output($sformatf("post rst idle%0d count", i), 32'(sb_count), 32'd0);
    end

    // Load accepted on a reset edge never completes
    apply_stimulus(1, 0, 32'h100, 32'h0, 3'd2, 0); reset = 1'b1;
    apply_stimulus(0, 0, 32'h0, 32'h0, 3'd0, 0); reset = 1'b0; #2;
    check_output("rst load dropped", 32'(ld_valid), 32'd0);
    apply_stimulus(1, 0, 32'h100, 32'h0, 3'd2, 0);
    apply_stimulus(0, 0, 32'h0, 32'h0, 3'd0, 0); #2;
    check_output("ram load valid", 32'(ld_valid), 32'd1);
    check_output("ram load data",  ld_data, 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Parametrised next-generation load/store unit core: sits between the MEM stage and the single-port synchronous data RAM.
- Stores are posted into a DEPTH-entry FIFO store buffer with write-combining, then drained to RAM in idle cycles.
- Loads read RAM with 1-cycle latency, with byte-accurate forwarding from all pending buffer entries.
- Adds a valid/ready handshake, a fence/drain mode and misaligned-access detection.

Parameters:
- DEPTH, 4, store-buffer entries (power of 2, >=2).
- ADDR_W, 16, RAM byte-address width; the word index is ADDR_W-2 bits.
- COMBINE_EN, 1, enables merging a store into the newest entry on a word-address match.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_wren  in  1  1=store, 0=load.
- i_req_addr  in  32  byte address; only [ADDR_W-1:0] used.
- i_req_wdata  in  32  store data (right-aligned).
- i_req_funct3  in  3  RV32 load/store funct3.
- i_fence  in  1  level; hold off requests until buffer empty.
- o_ld_valid  out  1  load data valid (1 cycle after accept).
- o_ld_data  out  32  extended load result.
- o_misaligned  out  1  pulse, 1 cycle after accepting a misaligned request.
- o_mem_addr  out  ADDR_W-2  RAM word index.
- o_mem_wdata  out  32  RAM write data.
- o_mem_bmask  out  4  RAM byte enables.
- o_mem_wren  out  1  RAM write strobe.
- i_mem_rdata  in  32  RAM read data, valid 1 cycle after o_mem_addr.
- o_sb_count  out  $clog2(DEPTH)+1  occupied entries.
- o_sb_empty  out  1  count==0.

Behaviour:
- Reset: pointers, count, o_ld_valid, o_misaligned, o_mem_wren cleared to 0; o_sb_empty=1; reset mid-load drops the pending o_ld_valid; buffered stores are discarded.
- Entry format: {word index, 32-bit lane-aligned data, 4-bit bmask}.
  - SB: bmask=0001<<addr[1:0], data={4{b}}.
  - SH: bmask=addr[1]?1100:0011, data={2{h}}.
  - SW: bmask=1111.
- Misaligned: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0. The request is accepted, has no buffer/RAM effect, gives no o_ld_valid, and o_misaligned=1 the next cycle. Illegal funct3 is treated the same way.
- o_req_ready = ~(count==DEPTH) & ~(i_fence & ~o_sb_empty). It never depends on i_req_valid.
- Port arbitration, one RAM access per cycle:
  - An accepted load uses the port; no drain that cycle.
  - Otherwise, if the buffer is non-empty, the head drains: o_mem_wren=1 with head addr/data/bmask, then pop.
  - When full, ready=0, so drain wins.
- Store enqueue:
  - If COMBINE_EN, count>0, the newest entry's word index matches, and the newest entry is not draining this cycle: OR the bmask into that entry and overwrite the selected bytes. Count is unchanged.
  - Otherwise push a new entry.
  - Push with a simultaneous drain leaves count unchanged.
- Load:
  - Cycle 0 (accept): drive o_mem_addr; compute forward bytes by scanning entries oldest to newest, newest byte wins; register fwd_data and fwd_mask.
  - Cycle 1: merged = per byte, fwd_mask ? fwd_data : i_mem_rdata.
  - Extract the byte/half at the captured addr[1:0].
  - Extend: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
  - o_ld_valid=1 with o_ld_data.
  - Back-to-back loads are fully pipelined.
- Pointers wrap modulo DEPTH. o_ld_data holds its last value when o_ld_valid=0.

Test Plan:
- Reset, then SW 0x11223344 @0x100, idle 1 cycle -> o_mem_wren=1, word index 0x40, bmask 1111; count 1->0.
- SW 0xAABBCCDD @0x200, then immediate LBU @0x202 -> next cycle o_ld_valid=1, o_ld_data=0x000000BB from forwarding; no RAM write during the load cycle.
- SB 0x80 @0x301, SB 0x7F @0x303 with COMBINE_EN=1 -> count stays 1, entry bmask 1010; after drain, LH @0x302 reads RAM and returns 0x00007Fxx with sign taken from byte 3.
- Fill DEPTH=4 distinct words while issuing continuous loads -> o_req_ready=0 at count 4, drain occurs, ready returns next cycle; count never exceeds 4.
- LW @0x102 -> o_misaligned=1 for one cycle, no o_ld_valid, count unchanged.
- 3 stores buffered, raise i_fence -> ready=0 for 3 drain cycles, ready=1 the cycle o_sb_empty=1; assert i_reset mid-sequence -> count=0 and no further o_mem_wren.
